// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack controller: token opcodes, error codes,
// FSM states and default geometry of the attached hardware stack.
package rpn_pkg;

  localparam int DEF_DEPTH = 64;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_XOR  = 3'd4,
    OP_DUP  = 3'd5,
    OP_DROP = 3'd6,
    OP_EMIT = 3'd7
  } op_e;

  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_POP1,
    ST_POP2,
    ST_CAP,
    ST_PUSH1,
    ST_PUSH2,
    ST_ERR
  } state_e;

  function automatic logic is_binary(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational two-operand unit; a is the former top of stack, b the word
// beneath it, so every result is b op a.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = b + a;
      OP_SUB:  result = b - a;
      OP_AND:  result = b & a;
      OP_XOR:  result = b ^ a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Sole master of one hardware stack: consumes RPN tokens, sequences the
// push/pop/clear strobes and tracks occupancy locally.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [2:0]       tok_op,
  input  logic [WIDTH-1:0] tok_data,
  output logic             stk_en,
  output logic             stk_rw,
  output logic             stk_clr,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_full,
  input  logic             stk_empty,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [6:0]       depth
);

  localparam logic [6:0] DEPTH_MAX = 7'(DEPTH);

  state_e           state;
  op_e              op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] res_hold;
  logic [WIDTH-1:0] alu_res;
  logic [1:0]       need_pop;
  logic             need_space;
  logic             underflow;
  logic             overflow;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_reg),
    .a      (a_reg),
    .b      (stk_dout),
    .result (alu_res)
  );

  // Operand and free-space requirements of the offered token, judged at accept.
  always_comb begin
    need_pop   = 2'd0;
    need_space = 1'b0;
    case (op_e'(tok_op))
      OP_PUSH: need_space = 1'b1;
      OP_DUP: begin
        need_pop   = 2'd1;
        need_space = 1'b1;
      end
      OP_DROP, OP_EMIT: need_pop = 2'd1;
      default: need_pop = 2'd2;
    endcase
    underflow = (depth < {5'd0, need_pop}) || ((need_pop != 2'd0) && stk_empty);
    overflow  = need_space && ((depth >= DEPTH_MAX) || stk_full);
  end

  // The popped word arrives a cycle after the strobe, so EMIT forwards it live.
  assign res_data = res_valid ? stk_dout : res_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      op_reg    <= OP_PUSH;
      a_reg     <= '0;
      res_hold  <= '0;
      tok_ready <= 1'b0;
      stk_en    <= 1'b0;
      stk_rw    <= 1'b0;
      stk_clr   <= 1'b0;
      stk_din   <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      depth     <= 7'd0;
    end else begin
      stk_en    <= 1'b0;
      stk_rw    <= 1'b0;
      stk_clr   <= 1'b0;
      stk_din   <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_INIT: begin
          if (!stk_clr) begin
            stk_en  <= 1'b1;
            stk_clr <= 1'b1;
          end else begin
            tok_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (tok_valid && tok_ready) begin
            tok_ready <= 1'b0;
            op_reg    <= op_e'(tok_op);
            if (underflow) begin
              err      <= 1'b1;
              err_code <= ERR_UNDERFLOW;
              state    <= ST_ERR;
            end else if (overflow) begin
              err      <= 1'b1;
              err_code <= ERR_OVERFLOW;
              state    <= ST_ERR;
            end else if (op_e'(tok_op) == OP_PUSH) begin
              stk_en  <= 1'b1;
              stk_rw  <= 1'b1;
              stk_din <= tok_data;
              depth   <= depth + 7'd1;
              state   <= ST_PUSH2;
            end else begin
              stk_en <= 1'b1;
              depth  <= (op_e'(tok_op) == OP_DUP) ? depth + 7'd1 : depth - 7'd1;
              state  <= ST_POP1;
            end
          end
        end
        ST_POP1: begin
          if (op_reg == OP_DROP) begin
            tok_ready <= 1'b1;
            state     <= ST_IDLE;
          end else if (op_reg == OP_EMIT) begin
            res_valid <= 1'b1;
            state     <= ST_CAP;
          end else if (is_binary(op_reg)) begin
            stk_en <= 1'b1;
            state  <= ST_POP2;
          end else begin
            state <= ST_CAP;
          end
        end
        ST_POP2: begin
          a_reg <= stk_dout;
          state <= ST_CAP;
        end
        ST_CAP: begin
          if (op_reg == OP_EMIT) begin
            res_hold  <= stk_dout;
            tok_ready <= 1'b1;
            state     <= ST_IDLE;
          end else if (op_reg == OP_DUP) begin
            a_reg   <= stk_dout;
            stk_en  <= 1'b1;
            stk_rw  <= 1'b1;
            stk_din <= stk_dout;
            state   <= ST_PUSH1;
          end else begin
            stk_en  <= 1'b1;
            stk_rw  <= 1'b1;
            stk_din <= alu_res;
            state   <= ST_PUSH2;
          end
        end
        ST_PUSH1: begin
          stk_en  <= 1'b1;
          stk_rw  <= 1'b1;
          stk_din <= a_reg;
          state   <= ST_PUSH2;
        end
        ST_PUSH2, ST_ERR: begin
          tok_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
